// File: rtl/calc_ctrl.sv
// calc_ctrl: debounces execute/clear buttons and sequences one ALU start/done operation into the accumulator
module calc_ctrl #(
  parameter int WIDTH      = 16,
  parameter int DEB_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btnc,
  input  logic             btnu,
  input  logic [3:0]       alu_op_in,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             ovf_flag,
  output logic             err_timeout
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  logic [1:0] raw, evt;
  logic clr_pend;
  logic [TW-1:0] tcnt;
  state_t state;
  assign raw = {btnu, btnc};
  assign alu_a = acc;
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic s1, s2, lvl, e;
    logic [DW-1:0] cnt;
    assign evt[i] = e;
    // e pulses on the same edge the debounced level rises
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
        lvl <= 1'b0;
        e <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        e <= 1'b0;
        if (s2 == lvl) cnt <= '0;
        else if (cnt == DW'(DEB_CYCLES - 1)) begin
          lvl <= s2;
          e <= s2;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      alu_b <= '0;
      alu_op <= '0;
      alu_start <= 1'b0;
      busy <= 1'b0;
      ovf_flag <= 1'b0;
      err_timeout <= 1'b0;
      clr_pend <= 1'b0;
      tcnt <= '0;
    end else begin
      alu_start <= 1'b0;
      if (state != IDLE && evt[1]) clr_pend <= 1'b1;
      case (state)
        IDLE:
          if (evt[1] || clr_pend) begin
            acc <= '0;
            ovf_flag <= 1'b0;
            err_timeout <= 1'b0;
            clr_pend <= 1'b0;
          end else if (evt[0]) begin
            alu_op <= alu_op_in;
            alu_b <= sw;
            alu_start <= 1'b1;
            busy <= 1'b1;
            state <= ISSUE;
          end
        ISSUE: begin
          tcnt <= '0;
          state <= WAIT;
        end
        WAIT:
          if (alu_done) begin
            acc <= alu_result;
            ovf_flag <= ovf_flag | alu_ovf;
            busy <= 1'b0;
            state <= IDLE;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else tcnt <= tcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed checks of debounce, handshake, timeout, deferred clear and reset
module tb_calc_ctrl;
  logic clk = 1'b0;
  logic rst_n, btnc, btnu, alu_start, alu_done, alu_ovf, busy, ovf_flag, err_timeout;
  logic [3:0] alu_op_in, alu_op;
  logic [15:0] sw, alu_a, alu_b, alu_result, acc;
  int total = 0;
  int bad = 0;
  int nstart = 0;
  int nb;
  calc_ctrl #(.WIDTH(16), .DEB_CYCLES(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .btnc(btnc), .btnu(btnu), .alu_op_in(alu_op_in), .sw(sw),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .acc(acc), .busy(busy), .ovf_flag(ovf_flag),
    .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (alu_start) nstart <= nstart + 1;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic press_c();
    btnc = 1'b1;
    tick(7);
    btnc = 1'b0;
    chk("press_start", 32'(alu_start), 1);
    chk("press_busy", 32'(busy), 1);
  endtask
  task automatic done(input logic [15:0] r, input logic v);
    alu_done = 1'b1;
    alu_result = r;
    alu_ovf = v;
    tick(1);
    alu_done = 1'b0;
    alu_ovf = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; btnc = 1'b0; btnu = 1'b0; alu_op_in = 4'h0; sw = 16'h0;
    alu_done = 1'b0; alu_result = 16'h0; alu_ovf = 1'b0;
    tick(2);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(alu_start), 0);
    chk("rst_flags", 32'({ovf_flag, err_timeout}), 0);
    rst_n = 1'b1;
    tick(2);
    // bouncing execute: two 3-cycle glitches must not reach the FSM
    nb = nstart;
    for (int k = 0; k < 2; k++) begin
      btnc = 1'b1; tick(3);
      btnc = 1'b0; tick(3);
    end
    tick(4);
    chk("bounce_busy", 32'(busy), 0);
    chk("bounce_nostart", 32'(nstart - nb), 0);
    btnc = 1'b1; sw = 16'h0005; alu_op_in = 4'h1;
    tick(6);
    chk("deb_early", 32'(alu_start), 0);
    tick(1);
    chk("deb_start", 32'(alu_start), 1);
    tick(1);
    chk("start_1cyc", 32'(alu_start), 0);
    done(16'h0005, 1'b0);
    chk("op0_acc", 32'(acc), 'h5);
    tick(2);
    btnc = 1'b0;
    tick(8);
    chk("bounce_one_start", 32'(nstart - nb), 1);
    // add: 5 + 3, done three cycles after start, busy four cycles
    sw = 16'h0003; alu_op_in = 4'h1;
    press_c();
    chk("add_a", 32'(alu_a), 'h5);
    chk("add_b", 32'(alu_b), 'h3);
    chk("add_op", 32'(alu_op), 'h1);
    sw = 16'hFFFF; alu_op_in = 4'hF;
    tick(1);
    chk("add_hold_b", 32'(alu_b), 'h3);
    chk("add_hold_op", 32'(alu_op), 'h1);
    chk("add_busy2", 32'(busy), 1);
    tick(2);
    chk("add_busy4", 32'(busy), 1);
    done(16'h0008, 1'b0);
    chk("add_acc", 32'(acc), 'h8);
    chk("add_busy_off", 32'(busy), 0);
    chk("add_ovf", 32'(ovf_flag), 0);
    tick(8);
    // timeout: exactly 64 WAIT cycles
    sw = 16'h1111;
    press_c();
    tick(64);
    chk("to_busy64", 32'(busy), 1);
    chk("to_err_early", 32'(err_timeout), 0);
    tick(1);
    chk("to_busy_off", 32'(busy), 0);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_acc", 32'(acc), 'h8);
    tick(8);
    // simultaneous execute and clear in IDLE: clear wins, no start
    nb = nstart;
    btnc = 1'b1; btnu = 1'b1;
    tick(7);
    chk("both_acc", 32'(acc), 0);
    chk("both_err", 32'(err_timeout), 0);
    chk("both_nostart", 32'(alu_start), 0);
    btnc = 1'b0; btnu = 1'b0;
    tick(8);
    chk("both_idle", 32'(busy), 0);
    chk("both_count", 32'(nstart - nb), 0);
    // done in the expiry cycle wins over timeout
    sw = 16'h0001;
    press_c();
    tick(64);
    done(16'hAAAA, 1'b1);
    chk("exp_acc", 32'(acc), 'hAAAA);
    chk("exp_err", 32'(err_timeout), 0);
    chk("exp_ovf", 32'(ovf_flag), 1);
    chk("exp_busy", 32'(busy), 0);
    tick(2);
    done(16'hDEAD, 1'b0);
    chk("idle_done_ignored", 32'(acc), 'hAAAA);
    tick(8);
    // clear during WAIT applied after result lands
    press_c();
    btnu = 1'b1;
    tick(9);
    btnu = 1'b0;
    chk("pend_busy", 32'(busy), 1);
    done(16'h1234, 1'b0);
    chk("pend_acc_res", 32'(acc), 'h1234);
    tick(1);
    chk("pend_acc_clr", 32'(acc), 0);
    chk("pend_flags", 32'({ovf_flag, err_timeout}), 0);
    tick(8);
    // execute during WAIT is dropped
    nb = nstart;
    press_c();
    tick(10);
    btnc = 1'b1;
    tick(8);
    btnc = 1'b0;
    chk("drop_busy", 32'(busy), 1);
    done(16'h0042, 1'b1);
    chk("drop_acc", 32'(acc), 'h42);
    tick(8);
    chk("drop_count", 32'(nstart - nb), 1);
    chk("drop_idle", 32'(busy), 0);
    // reset mid-WAIT, late done ignored
    sw = 16'h7777; alu_op_in = 4'h3;
    press_c();
    chk("r6_b", 32'(alu_b), 'h7777);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("r6_acc", 32'(acc), 0);
    chk("r6_regs", 32'({alu_b, alu_op}), 0);
    chk("r6_ctl", 32'({busy, alu_start, ovf_flag, err_timeout}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    done(16'h5555, 1'b1);
    chk("r6_late_acc", 32'(acc), 0);
    chk("r6_late_ctl", 32'({busy, ovf_flag}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
